// File: rtl/cohort_cfg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cohort_cfg_pkg
//  Brief    : Shared channel state encoding and width helpers for the cohort
//             configuration holder.
//  Revision : 1.0 - initial release
// ============================================================================
package cohort_cfg_pkg;

    typedef enum logic [1:0] {
        CFG_IDLE      = 2'd0,
        CFG_HOLD      = 2'd1,
        CFG_HOLD_PEND = 2'd2
    } cfg_state_e;

    // Index width for a select over n items; never narrower than one bit.
    function automatic int cfg_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cfg_bus_width(input int num_ch, input int words, input int word_w);
        return num_ch * words * word_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cohort_cfg_channel.sv
`default_nettype none
// ============================================================================
//  Module   : cohort_cfg_channel
//  Brief    : One configuration channel: FSM, active (and optional shadow)
//             word buffers, write-stall flag. Shadow buffer enabled by
//             COHORT_CFG_SHADOW_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module cohort_cfg_channel
    import cohort_cfg_pkg::*;
#(
    parameter int CFG_WORDS = 4,
    parameter int WORD_W    = 64,
    parameter int IDX_W     = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_wr_en,
    input  logic [IDX_W-1:0]            i_wr_idx,
    input  logic [WORD_W-1:0]           i_wr_data,
    input  logic                        i_wr_commit,
    input  logic                        i_ack,
    output logic                        o_valid,
    output logic                        o_stall,
    output logic [CFG_WORDS*WORD_W-1:0] o_data
);

    cfg_state_e        r_state;
    cfg_state_e        w_state_nxt;
    logic              w_wr_active;
    logic [WORD_W-1:0] r_active [CFG_WORDS];
`ifdef COHORT_CFG_SHADOW_EN
    logic              w_wr_shadow;
    logic              w_promote;
    logic [WORD_W-1:0] r_shadow [CFG_WORDS];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= CFG_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The top never grants a write to a channel that is being acked in the
    // same cycle, so write and ack paths below never collide.
    always_comb begin
        w_state_nxt = r_state;
        w_wr_active = 1'b0;
        o_stall     = 1'b0;
`ifdef COHORT_CFG_SHADOW_EN
        w_wr_shadow = 1'b0;
        w_promote   = 1'b0;
`endif
        case (r_state)
            CFG_IDLE: begin
                w_wr_active = i_wr_en;
`ifdef COHORT_CFG_SHADOW_EN
                w_wr_shadow = i_wr_en;
`endif
                if (i_wr_en && i_wr_commit) begin
                    w_state_nxt = CFG_HOLD;
                end
            end
            CFG_HOLD: begin
`ifdef COHORT_CFG_SHADOW_EN
                w_wr_shadow = i_wr_en;
                if (i_ack) begin
                    w_state_nxt = CFG_IDLE;
                end else if (i_wr_en && i_wr_commit) begin
                    w_state_nxt = CFG_HOLD_PEND;
                end
`else
                o_stall = 1'b1;
                if (i_ack) begin
                    w_state_nxt = CFG_IDLE;
                end
`endif
            end
`ifdef COHORT_CFG_SHADOW_EN
            CFG_HOLD_PEND: begin
                o_stall = 1'b1;
                if (i_ack) begin
                    w_promote   = 1'b1;
                    w_state_nxt = CFG_HOLD;
                end
            end
`endif
            default: begin
                w_state_nxt = CFG_IDLE;
            end
        endcase
    end

    assign o_valid = (r_state != CFG_IDLE);

    always_ff @(posedge clk) begin
        for (int w = 0; w < CFG_WORDS; w++) begin
            if (rst) begin
                r_active[w] <= '0;
            end else if (w_wr_active && (i_wr_idx == IDX_W'(w))) begin
                r_active[w] <= i_wr_data;
`ifdef COHORT_CFG_SHADOW_EN
            end else if (w_promote) begin
                r_active[w] <= r_shadow[w];
`endif
            end
        end
    end

`ifdef COHORT_CFG_SHADOW_EN
    always_ff @(posedge clk) begin
        for (int w = 0; w < CFG_WORDS; w++) begin
            if (rst) begin
                r_shadow[w] <= '0;
            end else if (w_wr_shadow && (i_wr_idx == IDX_W'(w))) begin
                r_shadow[w] <= i_wr_data;
            end
        end
    end
`endif

    for (genvar w = 0; w < CFG_WORDS; w++) begin : g_flat
        assign o_data[w*WORD_W +: WORD_W] = r_active[w];
    end

endmodule
`default_nettype wire

// File: rtl/cohort_cfg_holder.sv
`default_nettype none
// ============================================================================
//  Module   : cohort_cfg_holder
//  Brief    : Multi-channel config holder: channel decode, ready mux, error
//             pulse. Optional shadow buffering via COHORT_CFG_SHADOW_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module cohort_cfg_holder
    import cohort_cfg_pkg::*;
#(
    parameter  int NUM_CH    = 4,
    parameter  int CFG_WORDS = 4,
    parameter  int WORD_W    = 64,
    localparam int CH_W      = cfg_idx_width(NUM_CH),
    localparam int IDX_W     = cfg_idx_width(CFG_WORDS),
    localparam int BUS_W     = cfg_bus_width(NUM_CH, CFG_WORDS, WORD_W)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              cfg_wr_valid_i,
    output logic              cfg_wr_ready_o,
    input  logic [CH_W-1:0]   cfg_wr_ch_i,
    input  logic [IDX_W-1:0]  cfg_wr_idx_i,
    input  logic [WORD_W-1:0] cfg_wr_data_i,
    input  logic              cfg_wr_commit_i,
    output logic [NUM_CH-1:0] cfg_valid_o,
    output logic [BUS_W-1:0]  cfg_data_o,
    input  logic [NUM_CH-1:0] cfg_ack_i,
    output logic              cfg_err_o
);

    localparam int C_CH_SLICE = CFG_WORDS * WORD_W;

    logic [NUM_CH-1:0] w_sel;
    logic [NUM_CH-1:0] w_stall;
    logic              w_oor;
    logic              w_accept;
    logic              r_err;

    assign w_oor = (32'(cfg_wr_ch_i) >= 32'(NUM_CH)) || (32'(cfg_wr_idx_i) >= 32'(CFG_WORDS));

    // Out-of-range requests are always taken (and dropped) so the config
    // unit never deadlocks on a bad address.
    assign cfg_wr_ready_o = w_oor ? 1'b1 : ~(|(w_sel & (w_stall | cfg_ack_i)));
    assign w_accept       = cfg_wr_valid_i & cfg_wr_ready_o;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign w_sel[c] = (cfg_wr_ch_i == CH_W'(c));

        cohort_cfg_channel #(
            .CFG_WORDS (CFG_WORDS),
            .WORD_W    (WORD_W),
            .IDX_W     (IDX_W)
        ) u_channel (
            .clk         (clk_i),
            .rst         (reset_i),
            .i_wr_en     (w_accept & w_sel[c] & ~w_oor),
            .i_wr_idx    (cfg_wr_idx_i),
            .i_wr_data   (cfg_wr_data_i),
            .i_wr_commit (cfg_wr_commit_i),
            .i_ack       (cfg_ack_i[c]),
            .o_valid     (cfg_valid_o[c]),
            .o_stall     (w_stall[c]),
            .o_data      (cfg_data_o[c*C_CH_SLICE +: C_CH_SLICE])
        );
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_accept & w_oor;
        end
    end

    assign cfg_err_o = r_err;

endmodule
`default_nettype wire
